// File: rtl/axil_reg_slave.sv
// rtl/axil_reg_slave.sv - AXI-lite register slave: NREG RW registers plus one RO status word (optional AXIL_REG_SLAVE_SLVERR_EN)
module axil_reg_slave #(
    parameter int AW      = 12,
    parameter int DW      = 32,
    parameter int STRB    = 4,
    parameter int PROTW   = 3,
    parameter int RESPLEN = 2,
    parameter int NREG    = 8,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [AW-1:0]        awaddr,
    input  logic [PROTW-1:0]     awprot,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [DW-1:0]        wdata,
    input  logic [STRB-1:0]      wstrb,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [RESPLEN-1:0]   bresp,
    output logic                 bvalid,
    input  logic                 bready,
    input  logic [AW-1:0]        araddr,
    input  logic [PROTW-1:0]     arprot,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [DW-1:0]        rdata,
    output logic [RESPLEN-1:0]   rresp,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [NREG*DW-1:0]   reg_q,
    output logic [NREG-1:0]      wr_pulse,
    input  logic [DW-1:0]        status_in
);

    localparam int IW = AW - 2;
    localparam logic [IW-1:0] STATUS_IDX = IW'(NREG);
    localparam logic [RESPLEN-1:0] RESP_OKAY = '0;
`ifdef AXIL_REG_SLAVE_SLVERR_EN
    localparam logic [RESPLEN-1:0] RESP_SLVERR = RESPLEN'(2);
`endif

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    wr_state_t wr_state;
    rd_state_t rd_state;

    logic [DW-1:0]   regs [NREG];
    logic            aw_held;
    logic            w_held;
    logic [IW-1:0]   aw_idx_q;
    logic [DW-1:0]   w_data_q;
    logic [STRB-1:0] w_strb_q;

    logic            aw_hs;
    logic            w_hs;
    logic            ar_hs;
    logic            wr_go;
    logic [IW-1:0]   wr_idx;
    logic [DW-1:0]   wr_data;
    logic [STRB-1:0] wr_strb;
    logic [RESPLEN-1:0] wr_resp;
    logic [IW-1:0]   rd_idx;
    logic [DW-1:0]   rd_word;
    logic [RESPLEN-1:0] rd_resp;

    // prot and the byte offset within a word carry no meaning for this block
    logic unused_ok;
    assign unused_ok = &{1'b0, awprot, arprot, awaddr[1:0], araddr[1:0]};

    assign awready = (wr_state == WR_IDLE) && !aw_held;
    assign wready  = (wr_state == WR_IDLE) && !w_held;
    assign arready = (rd_state == RD_IDLE);

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    // A write fires once address and data are both present, held or arriving now
    assign wr_go   = (wr_state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_idx  = aw_held ? aw_idx_q : awaddr[AW-1:2];
    assign wr_data = w_held ? w_data_q : wdata;
    assign wr_strb = w_held ? w_strb_q : wstrb;
    assign rd_idx  = araddr[AW-1:2];

`ifdef AXIL_REG_SLAVE_SLVERR_EN
    assign wr_resp = (wr_idx < STATUS_IDX) ? RESP_OKAY : RESP_SLVERR;
    assign rd_resp = (rd_idx > STATUS_IDX) ? RESP_SLVERR : RESP_OKAY;
`else
    assign wr_resp = RESP_OKAY;
    assign rd_resp = RESP_OKAY;
`endif

    // Read mux: RW register, status word, or zero for anything out of range
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rd_idx == IW'(i)) begin
                rd_word = regs[i];
            end
        end
        if (rd_idx == STATUS_IDX) begin
            rd_word = status_in;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NREG; g++) begin : g_reg_q
            assign reg_q[g*DW +: DW] = regs[g];
        end
    endgenerate

    // Write channel: AW/W holding, byte-lane register update, pulse and B response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= WR_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            wr_pulse <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= RST_VAL;
            end
        end else begin
            wr_pulse <= '0;
            case (wr_state)
                WR_IDLE: begin
                    if (wr_go) begin
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        bvalid   <= 1'b1;
                        bresp    <= wr_resp;
                        wr_state <= WR_RESP;
                        for (int i = 0; i < NREG; i++) begin
                            if (wr_idx == IW'(i)) begin
                                wr_pulse[i] <= 1'b1;
                                for (int b = 0; b < STRB; b++) begin
                                    if (wr_strb[b]) begin
                                        regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                                    end
                                end
                            end
                        end
                    end else begin
                        if (aw_hs) begin
                            aw_held  <= 1'b1;
                            aw_idx_q <= awaddr[AW-1:2];
                        end
                        if (w_hs) begin
                            w_held   <= 1'b1;
                            w_data_q <= wdata;
                            w_strb_q <= wstrb;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid   <= 1'b0;
                        wr_state <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read channel: latch data at AR acceptance and hold it until R completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            rvalid   <= 1'b0;
            rresp    <= RESP_OKAY;
            rdata    <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rdata    <= rd_word;
                        rresp    <= rd_resp;
                        rvalid   <= 1'b1;
                        rd_state <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (rready) begin
                        rvalid   <= 1'b0;
                        rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule
